// File: rtl/mux_arbiter_pkg.sv
// Shared constants, state encoding and round-robin pick helper for mux_arbiter.
package mux_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Returns {found, index}: first set bit of valid scanning upward from ptr, wrapping.
    function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0]  valid,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W:0]   res;
        res = '0;
        // Scan from the farthest offset down so the nearest hit is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4.sv
// 4:1 single-bit mux tree: two first-level muxes on sel[0], one on sel[1].
module mux4 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    logic lo;
    logic hi;

    assign lo = sel[0] ? d[1] : d[0];
    assign hi = sel[0] ? d[3] : d[2];
    assign y  = sel[1] ? hi : lo;

endmodule

// File: rtl/mux_arbiter.sv
// 4-requester round-robin arbiter feeding a one-word registered output slot.
// Define MUX_ARBITER_PRIO0_EN to give requester 0 absolute priority over the round-robin scan.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      grant_sel
);

    // Handshakes: a requester transfers on req_valid[i] && req_ready[i]; the consumer
    // takes out_data on out_valid && out_ready. A draining slot may refill in the same cycle.

    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] win_data;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef MUX_ARBITER_PRIO0_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end else begin
            {win_found, win_idx} = rr_pick(req_valid, rr_ptr);
        end
`else
        {win_found, win_idx} = rr_pick(req_valid, rr_ptr);
`endif
    end

    // rst gates ready so nothing handshakes while the slot is being cleared.
    assign slot_free = (state == EMPTY) || out_ready;
    assign accept    = slot_free && win_found && !rst;
    assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
    assign out_valid = (state == FULL);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NREQ-1:0] bits;
        assign bits = {req_data[3*WIDTH + b], req_data[2*WIDTH + b],
                       req_data[WIDTH + b],   req_data[b]};
        mux4 u_mux4 (
            .d   (bits),
            .sel (win_idx),
            .y   (win_data[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_data  <= '0;
            grant_sel <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            state     <= FULL;
            out_data  <= win_data;
            grant_sel <= win_idx;
`ifdef MUX_ARBITER_PRIO0_EN
            // Priority grants to requester 0 do not disturb the rotation among 1-3.
            if (win_idx != '0) rr_ptr <= win_idx + SEL_W'(1);
`else
            rr_ptr    <= win_idx + SEL_W'(1);
`endif
        end else if (slot_free) begin
            state <= EMPTY;
        end
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data bits per requester.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  4  per-requester valid.
REQ-005 Port: req_data  input  4*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-006 Port: req_ready  output  4  one-hot or zero; requester i transfers when req_valid[i] && req_ready[i].
REQ-007 Port: out_valid  output  1  registered output holds a word.
REQ-008 Port: out_data  output  WIDTH  registered granted word.
REQ-009 Port: out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-010 Port: grant_sel  output  2  index of the requester whose word sits in out_data.

Function
REQ-011 Two states SHALL exist: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 Slot free SHALL be defined as EMPTY, or FULL with out_ready=1.
REQ-013 When the slot is free and any req_valid is set, the winner SHALL be the first set req_valid found scanning circularly from rr_ptr upward (3 wraps to 0).
REQ-014 req_ready SHALL assert only for the winner, only while the slot is free; otherwise req_ready=4'b0000.
REQ-015 req_ready SHALL be combinational from req_valid, rr_ptr, out_valid and out_ready.
REQ-016 On accept: out_data <= winner's word, grant_sel <= winner, out_valid <= 1, rr_ptr <= (winner+1) mod 4; latency is 1 cycle from accept to out_valid.
REQ-017 FULL with out_ready=1 and a winner present: drain and accept in the same cycle; the state stays FULL with the new word.
REQ-018 FULL with out_ready=1 and no req_valid: transition to EMPTY; out_data and grant_sel hold.
REQ-019 FULL with out_ready=0: out_data, grant_sel and rr_ptr SHALL hold; req_ready=0.
REQ-020 No accept SHALL leave rr_ptr unchanged.
REQ-021 A requester SHALL never be starved while out_ready is eventually asserted; the bound is 3 other grants.

Reset
REQ-022 While rst=1: out_valid=0, out_data=0, grant_sel=0, rr_ptr=0, req_ready=0, regardless of clk.
REQ-023 Reset mid-transfer SHALL discard the held word with no handshake completed.

Configuration
REQ-024 With MUX_ARBITER_PRIO0_EN defined, requester 0 SHALL win whenever req_valid[0]=1; the remaining requesters use the round-robin scan. rr_ptr SHALL update only on grants to requesters 1-3.
REQ-025 Without MUX_ARBITER_PRIO0_EN, pure round-robin per REQ-013 applies and no priority logic is synthesized.

Structure
REQ-026 A shared package mux_arbiter_pkg SHALL hold the NREQ=4 and SEL_W=2 constants and the state enum (EMPTY, FULL).
REQ-027 Winner data selection SHALL instantiate the team's 4:1 mux tree sub-module mux4 once per data bit, with select = winner index; no other sub-modules.

Verification
REQ-028 Reset: with rst=1 asserted asynchronously mid-FULL, out_valid=0, req_ready=0000 and grant_sel=0 immediately; after release, the first grant with all valid goes to 0.
REQ-029 Fairness: WIDTH=8, all four valid with data 8'hA0..8'hA3, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 and grant_sel 0,1,2,3,0 on consecutive cycles.
REQ-030 Backpressure: FULL with 8'h5C, out_ready=0 for 5 cycles, all valid -> out_data stays 5C and req_ready=0000; first out_ready=1 cycle shows a new grant at the next rr_ptr.
REQ-031 Wrap: rr_ptr=3, only req_valid[2]=1 -> req_ready=0100, grant_sel=2, rr_ptr=3 afterward.
REQ-032 Drain-to-empty: FULL, out_ready=1, req_valid=0000 -> out_valid=0 next cycle, rr_ptr unchanged.
REQ-033 Macro: req_valid=0011 held, out_ready=1 -> with MUX_ARBITER_PRIO0_EN grants 0,0,0,0; without it grants 0,1,0,1.
